// File: rtl/rf_bypass.sv
// Operand register file for the bitwise logic unit: 2**SELW x N flops, two
// combinational read ports with same-cycle write bypass, one synchronous write port.
module rf_bypass #(
   parameter int N    = 16,
   parameter int SELW = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [SELW-1:0] read1RegSel,
   input  logic [SELW-1:0] read2RegSel,
   input  logic [SELW-1:0] writeRegSel,
   input  logic [N-1:0]    writeData,
   input  logic            writeEn,
   output logic [N-1:0]    read1Data,
   output logic [N-1:0]    read2Data,
   output logic            err
);

   localparam int DEPTH = 2 ** SELW;

   logic [N-1:0] regs_q [DEPTH];
   logic [N-1:0] regs_d [DEPTH];
   logic         err_q;
   logic         err_d;
   logic         err_set;

`ifdef SYNTHESIS
   assign err_set = 1'b0;
`else
   // Unknown write controls or data poison the file; only observable in 4-state simulation.
   assign err_set = $isunknown({writeEn, writeRegSel, writeData});
`endif

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         regs_d[i] = regs_q[i];
         if (writeEn && (writeRegSel == SELW'(i))) begin
            regs_d[i] = writeData;
         end
      end
      err_d = err_q | err_set;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
         err_q <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= regs_d[i];
         end
         err_q <= err_d;
      end
   end

   // Bypass forwards the pending write so the stored value after the edge matches what was read before it.
   always_comb begin
      read1Data = '0;
      read2Data = '0;
      if (!rst) begin
         if (writeEn && (writeRegSel == read1RegSel)) begin
            read1Data = writeData;
         end else begin
            read1Data = regs_q[read1RegSel];
         end
         if (writeEn && (writeRegSel == read2RegSel)) begin
            read2Data = writeData;
         end else begin
            read2Data = regs_q[read2RegSel];
         end
      end
   end

   assign err = err_q;

endmodule
